robot_move_sequencer: RTL and testbench

Controller that sequences the pipe-cleaning robot through the 10x20 world map, one step at a time.
- Owns the robot pose registers: row, column, orientation.
- Paces steps with an internal step timer and requests sensor data from the map block with a req/ack handshake.
- Picks one action per step using a left-hand wall-following rule and clamps all motion to the map.
- Sits between the world's map/sensor logic and the display/monitor logic.

---
 rtl/robot_pkg.sv | 54 +++++
 rtl/robot_next_pose.sv | 57 +++++
 rtl/robot_move_sequencer.sv | 130 +++++++++++++
 tb/tb_robot_move_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/robot_pkg.sv
// Shared types for the robot move sequencer: orientation encodings, actions,
// FSM states, pose record and default map size.
package robot_pkg;

  localparam int DEFAULT_ROWS = 10;
  localparam int DEFAULT_COLS = 20;

  typedef enum logic [1:0] {
    NORTH = 2'b00,
    SOUTH = 2'b01,
    EAST  = 2'b10,
    WEST  = 2'b11
  } orient_t;

  typedef enum logic [1:0] {
    FORWARD,
    ROTATE_LEFT,
    ROTATE_RIGHT
  } action_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    REQ,
    ACT,
    HALT
  } state_t;

  typedef struct packed {
    logic [5:0] row;
    logic [5:0] col;
    orient_t    orient;
  } pose_t;

  // Clockwise order is N -> E -> S -> W -> N.
  function automatic orient_t rotate_right(input orient_t o);
    unique case (o)
      NORTH: return EAST;
      EAST:  return SOUTH;
      SOUTH: return WEST;
      WEST:  return NORTH;
    endcase
  endfunction

  function automatic orient_t rotate_left(input orient_t o);
    unique case (o)
      NORTH: return WEST;
      WEST:  return SOUTH;
      SOUTH: return EAST;
      EAST:  return NORTH;
    endcase
  endfunction

endpackage

// File: rtl/robot_next_pose.sv
// Combinational step decision: left-hand wall following with the map border
// treated as an obstacle ahead.
module robot_next_pose
  import robot_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,
  parameter int COLS = DEFAULT_COLS
) (
  input  pose_t   pose,
  input  logic    head,
  input  logic    left,
  input  logic    last_left,
  output logic    head_eff,
  output pose_t   next_pose,
  output action_t action
);

  localparam logic [5:0] ROW_MAX = 6'(ROWS);
  localparam logic [5:0] COL_MAX = 6'(COLS);

  logic at_edge;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statements can infer a latch.
  always_comb begin
    at_edge   = 1'b0;
    next_pose = pose;
    action    = ROTATE_RIGHT;

    unique case (pose.orient)
      NORTH: at_edge = (pose.row == 6'd1);
      SOUTH: at_edge = (pose.row == ROW_MAX);
      EAST:  at_edge = (pose.col == COL_MAX);
      WEST:  at_edge = (pose.col == 6'd1);
    endcase

    head_eff = head | at_edge;

    if (!left && !last_left) begin
      action           = ROTATE_LEFT;
      next_pose.orient = rotate_left(pose.orient);
    end else if (!head_eff) begin
      // Forward is only chosen when the target cell is inside the map.
      action = FORWARD;
      unique case (pose.orient)
        NORTH: next_pose.row = pose.row - 6'd1;
        SOUTH: next_pose.row = pose.row + 6'd1;
        EAST:  next_pose.col = pose.col + 6'd1;
        WEST:  next_pose.col = pose.col - 6'd1;
      endcase
    end else begin
      action           = ROTATE_RIGHT;
      next_pose.orient = rotate_right(pose.orient);
    end
  end

endmodule

// File: rtl/robot_move_sequencer.sv
// Step sequencer for the pipe-cleaning robot: pacing timer, sensor handshake,
// pose registers and stuck detection. Optional forward-move counter under
// ROBOT_STEP_COUNT_EN.
module robot_move_sequencer
  import robot_pkg::*;
#(
  parameter int         STEP_CYCLES  = 2,
  parameter int         ROWS         = DEFAULT_ROWS,
  parameter int         COLS         = DEFAULT_COLS,
  parameter int         START_ROW    = 1,
  parameter int         START_COL    = 1,
  parameter logic [1:0] START_ORIENT = 2'b00
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        enable,
  output logic        sensor_req,
  input  logic        sensor_ack,
  input  logic        head,
  input  logic        left,
  output logic [5:0]  robot_row,
  output logic [5:0]  robot_column,
  output logic [1:0]  robot_orientation,
  output logic        step_done,
  output logic        stuck,
  output logic [15:0] step_count
);

  localparam int TIMER_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(STEP_CYCLES - 1);
  localparam pose_t START_POSE = '{row: 6'(START_ROW), col: 6'(START_COL),
                                   orient: orient_t'(START_ORIENT)};

  state_t               state, next_state;
  logic [TIMER_W-1:0]   timer;
  pose_t                pose, next_pose;
  logic                 head_q, left_q, last_left;
  logic [2:0]           turn_cnt;
  logic                 head_eff, turning_right, stuck_set;
  action_t              action;

  robot_next_pose #(.ROWS(ROWS), .COLS(COLS)) u_next_pose (
    .pose      (pose),
    .head      (head_q),
    .left      (left_q),
    .last_left (last_left),
    .head_eff  (head_eff),
    .next_pose (next_pose),
    .action    (action)
  );

  // A right turn is any blocked step that is not preempted by a left turn.
  assign turning_right = head_eff && (action != ROTATE_LEFT);
  assign stuck_set     = (state == ACT) && turning_right && (turn_cnt == 3'd3);

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (enable) next_state = WAIT;
      WAIT: if (timer == '0) next_state = REQ;
      REQ:  if (sensor_ack) next_state = ACT;
      ACT:  begin
        if (stuck_set)   next_state = HALT;
        else if (enable) next_state = WAIT;
        else             next_state = IDLE;
      end
      HALT: next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      pose       <= START_POSE;
      head_q     <= 1'b0;
      left_q     <= 1'b0;
      last_left  <= 1'b0;
      turn_cnt   <= '0;
      stuck      <= 1'b0;
      sensor_req <= 1'b0;
      step_done  <= 1'b0;
    end else begin
      state      <= next_state;
      sensor_req <= (next_state == REQ);
      step_done  <= (state == ACT);

      if (next_state == WAIT && state != WAIT)
        timer <= TIMER_LOAD;
      else if (state == WAIT && timer != '0)
        timer <= timer - 1'b1;

      if (state == REQ && sensor_ack) begin
        head_q <= head;
        left_q <= left;
      end

      if (state == ACT) begin
        pose      <= next_pose;
        last_left <= (action == ROTATE_LEFT);
        turn_cnt  <= turning_right ? turn_cnt + 3'd1 : 3'd0;
      end

      if (stuck_set) stuck <= 1'b1;
    end
  end

  assign robot_row         = pose.row;
  assign robot_column      = pose.col;
  assign robot_orientation = pose.orient;

`ifdef ROBOT_STEP_COUNT_EN
  logic [15:0] fwd_count;

  always_ff @(posedge clock_50) begin
    if (reset)
      fwd_count <= '0;
    else if (state == ACT && action == FORWARD && fwd_count != 16'hFFFF)
      fwd_count <= fwd_count + 16'd1;
  end

  assign step_count = fwd_count;
`else
  assign step_count = '0;
`endif

endmodule

// File: tb/tb_robot_move_sequencer.sv
// Scoreboard bench for robot_move_sequencer: a behavioural model predicts each
// step's pose when the ack is driven; the monitor compares on step_done.
module tb_robot_move_sequencer;

  localparam int ROWS = 10;
  localparam int COLS = 20;

  logic        clock_50 = 1'b0;
  logic        reset, enable, sensor_ack, head, left;
  logic        sensor_req, step_done, stuck;
  logic [5:0]  robot_row, robot_column;
  logic [1:0]  robot_orientation;
  logic [15:0] step_count;

  robot_move_sequencer #(
    .STEP_CYCLES (2),
    .ROWS        (ROWS),
    .COLS        (COLS),
    .START_ROW   (1),
    .START_COL   (1),
    .START_ORIENT(2'b00)
  ) dut (
    .clock_50          (clock_50),
    .reset             (reset),
    .enable            (enable),
    .sensor_req        (sensor_req),
    .sensor_ack        (sensor_ack),
    .head              (head),
    .left              (left),
    .robot_row         (robot_row),
    .robot_column      (robot_column),
    .robot_orientation (robot_orientation),
    .step_done         (step_done),
    .stuck             (stuck),
    .step_count        (step_count)
  );

  always #10 clock_50 = ~clock_50;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Orientation codes: N=0, S=1, E=2, W=3.
  int cw_next[4]  = '{2, 3, 1, 0};
  int ccw_next[4] = '{3, 2, 0, 1};
  int d_row[4]    = '{-1, 1, 0, 0};
  int d_col[4]    = '{0, 0, 1, -1};

  typedef struct {
    int   row;
    int   col;
    int   orient;
    logic stuck;
    int   cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int   m_row, m_col, m_or, m_tc, m_cnt;
  logic m_ll, m_stuck;

  task automatic model_reset();
    m_row = 1; m_col = 1; m_or = 0; m_tc = 0; m_cnt = 0;
    m_ll = 1'b0; m_stuck = 1'b0;
  endtask

  task automatic model_step(input logic h, input logic l);
    int   nr, nc;
    logic blocked;
    nr = m_row + d_row[m_or];
    nc = m_col + d_col[m_or];
    blocked = h || nr < 1 || nr > ROWS || nc < 1 || nc > COLS;
    if (!l && !m_ll) begin
      m_or = ccw_next[m_or]; m_ll = 1'b1; m_tc = 0;
    end else if (!blocked) begin
      m_row = nr; m_col = nc; m_ll = 1'b0; m_tc = 0;
`ifdef ROBOT_STEP_COUNT_EN
      if (m_cnt < 65535) m_cnt++;
`endif
    end else begin
      m_or = cw_next[m_or]; m_ll = 1'b0; m_tc++;
      if (m_tc == 4) m_stuck = 1'b1;
    end
    sb.push_back('{row: m_row, col: m_col, orient: m_or, stuck: m_stuck, cnt: m_cnt});
  endtask

  always @(negedge clock_50) begin
    if (step_done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_step_done", 32'(step_done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("step_row",    32'(robot_row),         32'(mon_e.row));
        check("step_col",    32'(robot_column),      32'(mon_e.col));
        check("step_orient", 32'(robot_orientation), 32'(mon_e.orient));
        check("step_stuck",  32'(stuck),             32'(mon_e.stuck));
        check("step_count",  32'(step_count),        32'(mon_e.cnt));
      end
    end
  end

  task automatic check_pose_vs_model(input string tag);
    check({tag, "_pose"}, 32'({robot_row, robot_column, robot_orientation}),
          32'({6'(m_row), 6'(m_col), 2'(m_or)}));
  endtask

  task automatic check_reset_state(input string tag);
    check_pose_vs_model(tag);
    check({tag, "_req"},   32'(sensor_req), 32'd0);
    check({tag, "_done"},  32'(step_done),  32'd0);
    check({tag, "_stuck"}, 32'(stuck),      32'd0);
    check({tag, "_count"}, 32'(step_count), 32'd0);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock_50);
      check(tag, 32'(sensor_req), 32'd0);
    end
  endtask

  task automatic wait_req(output logic ok);
    int waited = 0;
    while (sensor_req !== 1'b1 && waited < 40) begin
      @(negedge clock_50);
      waited++;
    end
    ok = (sensor_req === 1'b1);
    if (!ok) check("req_timeout", 32'(sensor_req), 32'd1);
  endtask

  // One full step: wait for the request, optionally stall the ack, then
  // verify the N+1 latency and single-cycle step_done.
  task automatic do_step(input logic h, input logic l, input int hold, input logic drop_en);
    logic ok;
    wait_req(ok);
    if (!ok) return;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock_50);
      check("req_held", 32'(sensor_req), 32'd1);
      check_pose_vs_model("stall");
    end
    head = h; left = l; sensor_ack = 1'b1;
    if (drop_en) enable = 1'b0;
    model_step(h, l);
    @(negedge clock_50);
    sensor_ack = 1'b0;
    head = 1'($urandom_range(1, 0));
    left = 1'($urandom_range(1, 0));
    check("done_too_early", 32'(step_done), 32'd0);
    @(negedge clock_50);
    check("done_latency", 32'(step_done), 32'd1);
    @(negedge clock_50);
    check("done_one_cycle", 32'(step_done), 32'd0);
  endtask

  initial begin
    logic ok;
    reset = 1'b1; enable = 1'b0; sensor_ack = 1'b0; head = 1'b0; left = 1'b0;
    model_reset();
    repeat (3) @(negedge clock_50);
    reset = 1'b0;
    check_reset_state("reset");
    idle_check("idle_no_req", 4);

    enable = 1'b1;
    do_step(1'b0, 1'b1, 0, 1'b0);           // north edge at row 1 -> east
    do_step(1'b0, 1'b1, 0, 1'b0);           // (1,2) east
    do_step(1'b0, 1'b1, 5, 1'b0);           // stalled ack, then (1,3)
    do_step(1'b0, 1'b1, 0, 1'b0);           // (1,4)
    do_step(1'b1, 1'b1, 0, 1'b0);           // blocked -> south
    repeat (4) do_step(1'b0, 1'b1, 0, 1'b0); // (5,4) south
    do_step(1'b0, 1'b0, 0, 1'b0);           // left turn -> east
    do_step(1'b0, 1'b0, 0, 1'b0);           // no second left: (5,5) east
    do_step(1'b0, 1'b0, 0, 1'b0);           // left turn -> (5,5) north
    do_step(1'b0, 1'b0, 0, 1'b0);           // forward -> (4,5) north

    repeat (4) do_step(1'b1, 1'b1, 0, 1'b0); // E,S,W,N then stuck
    check("stuck_after_4", 32'(stuck), 32'd1);
    idle_check("halt_no_req", 12);
    check_pose_vs_model("halt_frozen");

    reset = 1'b1;
    @(negedge clock_50);
    reset = 1'b0;
    model_reset();
    check_reset_state("reset_from_halt");
    wait_req(ok);
    reset = 1'b1;
    @(negedge clock_50);
    check_reset_state("reset_in_req");
    reset = 1'b0;

    do_step(1'b0, 1'b1, 0, 1'b1);           // enable dropped mid-step
    idle_check("disabled_idle", 8);
    enable = 1'b1;
    repeat (19) do_step(1'b0, 1'b1, 0, 1'b0); // (1,20) east
    do_step(1'b0, 1'b1, 0, 1'b0);           // east edge at col 20 -> south
    repeat (2) do_step(1'b0, 1'b1, 0, 1'b0); // (3,20) south
    do_step(1'b0, 1'b0, 0, 1'b0);           // left turn -> east
    do_step(1'b0, 1'b1, 0, 1'b0);           // edge -> south, column stays 20
    check("col_clamped", 32'(robot_column), 32'd20);

    repeat (4) @(negedge clock_50);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
